// File: rtl/robo_nav_ctrl.sv
// robo_nav_ctrl: navigation FSM between the sensor front-end and the motor/collector drivers.
// Latency: sensors sampled on a clock edge are reflected on the registered outputs right after that edge.
// Backpressure: none; sensors are level inputs sampled every cycle and the outputs are level commands.
//
// Ports:
//   clock, reset (async, active-high)    - clocking / reset
//   start                                - leave STANDBY (only looked at in STANDBY)
//   head, left, under, barrier           - obstacle ahead, wall on left, cliff, debris ahead
//   avancar, girar, girar_esq            - forward drive, one-cycle turn pulse, turn is CCW
//   recolher_entulho                     - collector active
//   direcao [DIR_W-1:0]                  - current heading (clockwise encoding)
//   standby, parado                      - idle / latched stop indicators
//   fault_code [1:0]                     - 00 none, 01 cliff, 10 trapped, 11 debris blocked by wall
//   entulho_cnt [CNT_W-1:0]              - completed pickups, saturating
//
// Build option: define ROBO_WALL_FOLLOW_EN to turn left (CCW) out of AVANCAR when the
// left wall disappears. Without it, `left` is ignored and girar_esq stays 0.

module robo_nav_ctrl #(
  parameter int DIR_W       = 2,
  parameter int DIR_INIT    = 0,
  parameter int COLLECT_CYC = 4,
  parameter int CNT_W       = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             head,
  input  logic             left,
  input  logic             under,
  input  logic             barrier,
  output logic             avancar,
  output logic             girar,
  output logic             girar_esq,
  output logic             recolher_entulho,
  output logic [DIR_W-1:0] direcao,
  output logic             standby,
  output logic             parado,
  output logic [1:0]       fault_code,
  output logic [CNT_W-1:0] entulho_cnt
);

  typedef enum logic [2:0] {
    ST_STANDBY    = 3'd0,
    ST_AVANCAR    = 3'd1,
    ST_ROTACIONAR = 3'd2,
    ST_RECOLHER   = 3'd3,
    ST_PARADO     = 3'd4
  } state_t;

  localparam int                COL_W    = (COLLECT_CYC > 1) ? $clog2(COLLECT_CYC) : 1;
  localparam logic [COL_W-1:0]  COL_LOAD = COL_W'(COLLECT_CYC - 1);
  // rot_cnt reaching the number of headings means a full clockwise circle was tried.
  localparam logic [DIR_W:0]    ROT_FULL = (DIR_W + 1)'(2 ** DIR_W);
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [DIR_W-1:0]  DIR_RST  = DIR_W'(DIR_INIT);

  localparam logic [1:0] FLT_NONE    = 2'b00;
  localparam logic [1:0] FLT_CLIFF   = 2'b01;
  localparam logic [1:0] FLT_TRAPPED = 2'b10;
  localparam logic [1:0] FLT_BLOCKED = 2'b11;

  state_t             r_state;
  logic [DIR_W-1:0]   r_dir;
  logic [DIR_W:0]     r_rot;
  logic [COL_W-1:0]   r_col;
  logic [1:0]         r_fault;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_avancar;
  logic               r_girar;
  logic               r_girar_esq;
  logic               r_recolher;
  logic               r_standby;
  logic               r_parado;

  // Dispatch decision shared by every state that re-evaluates the sensors.
  state_t             w_d_state;
  logic [DIR_W-1:0]   w_d_dir;
  logic [DIR_W:0]     w_d_rot;
  logic [COL_W-1:0]   w_d_col;
  logic [1:0]         w_d_fault;
  logic               w_d_ccw;

  state_t             w_nxt_state;
  logic [DIR_W-1:0]   w_nxt_dir;
  logic [DIR_W:0]     w_nxt_rot;
  logic [COL_W-1:0]   w_nxt_col;
  logic [1:0]         w_nxt_fault;
  logic [CNT_W-1:0]   w_nxt_cnt;
  logic               w_nxt_ccw;
  logic               w_take;

`ifndef ROBO_WALL_FOLLOW_EN
  logic w_unused_left;
  assign w_unused_left = left;
`endif

  always_comb begin
    w_d_state = ST_AVANCAR;
    w_d_dir   = r_dir;
    w_d_rot   = '0;
    w_d_col   = r_col;
    w_d_fault = r_fault;
    w_d_ccw   = 1'b0;
    if (under) begin
      w_d_state = ST_PARADO;
      w_d_fault = FLT_CLIFF;
    end else if (barrier && head) begin
      w_d_state = ST_PARADO;
      w_d_fault = FLT_BLOCKED;
    end else if (barrier) begin
      w_d_state = ST_RECOLHER;
      w_d_col   = COL_LOAD;
    end else if (head && (r_rot == ROT_FULL)) begin
      w_d_state = ST_PARADO;
      w_d_fault = FLT_TRAPPED;
      w_d_rot   = r_rot;
    end else if (head) begin
      w_d_state = ST_ROTACIONAR;
      w_d_dir   = r_dir + 1'b1;
      w_d_rot   = r_rot + 1'b1;
`ifdef ROBO_WALL_FOLLOW_EN
    end else if ((r_state == ST_AVANCAR) && !left) begin
      // Only taken out of AVANCAR, so a left turn is always followed by a re-check.
      w_d_state = ST_ROTACIONAR;
      w_d_dir   = r_dir - 1'b1;
      w_d_ccw   = 1'b1;
`endif
    end
  end

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_dir   = r_dir;
    w_nxt_rot   = r_rot;
    w_nxt_col   = r_col;
    w_nxt_fault = r_fault;
    w_nxt_cnt   = r_cnt;
    w_nxt_ccw   = 1'b0;
    w_take      = 1'b0;
    case (r_state)
      ST_STANDBY:    w_take = start;
      ST_AVANCAR:    w_take = 1'b1;
      ST_ROTACIONAR: w_take = 1'b1;
      ST_RECOLHER: begin
        if (r_col != '0) begin
          // Mid-pickup only a cliff can interrupt; the pickup is then not counted.
          if (under) begin
            w_nxt_state = ST_PARADO;
            w_nxt_fault = FLT_CLIFF;
          end else begin
            w_nxt_col = r_col - 1'b1;
          end
        end else begin
          w_nxt_cnt = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
          w_take    = 1'b1;
        end
      end
      ST_PARADO:     w_take = 1'b0;
      default:       w_nxt_state = ST_STANDBY;
    endcase
    if (w_take) begin
      w_nxt_state = w_d_state;
      w_nxt_dir   = w_d_dir;
      w_nxt_rot   = w_d_rot;
      w_nxt_col   = w_d_col;
      w_nxt_fault = w_d_fault;
      w_nxt_ccw   = w_d_ccw;
    end
  end

  // State, datapath and decoded outputs all register together so outputs never glitch.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= ST_STANDBY;
      r_dir       <= DIR_RST;
      r_rot       <= '0;
      r_col       <= '0;
      r_fault     <= FLT_NONE;
      r_cnt       <= '0;
      r_avancar   <= 1'b0;
      r_girar     <= 1'b0;
      r_girar_esq <= 1'b0;
      r_recolher  <= 1'b0;
      r_standby   <= 1'b1;
      r_parado    <= 1'b0;
    end else begin
      r_state     <= w_nxt_state;
      r_dir       <= w_nxt_dir;
      r_rot       <= w_nxt_rot;
      r_col       <= w_nxt_col;
      r_fault     <= w_nxt_fault;
      r_cnt       <= w_nxt_cnt;
      r_avancar   <= (w_nxt_state == ST_AVANCAR);
      r_girar     <= (w_nxt_state == ST_ROTACIONAR);
      r_girar_esq <= (w_nxt_state == ST_ROTACIONAR) && w_nxt_ccw;
      r_recolher  <= (w_nxt_state == ST_RECOLHER);
      r_standby   <= (w_nxt_state == ST_STANDBY);
      r_parado    <= (w_nxt_state == ST_PARADO);
    end
  end

  assign avancar          = r_avancar;
  assign girar            = r_girar;
  assign girar_esq        = r_girar_esq;
  assign recolher_entulho = r_recolher;
  assign direcao          = r_dir;
  assign standby          = r_standby;
  assign parado           = r_parado;
  assign fault_code       = r_fault;
  assign entulho_cnt      = r_cnt;

endmodule
